st_bcast_splitter: RTL

ST_BCAST_SPLITTER -- requirements
Module: st_bcast_splitter

---
 rtl/st_pkg.sv | 21 ++
 rtl/st_fifo.sv | 85 ++++++++
 rtl/st_bcast_splitter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/st_pkg.sv
// ---------------------------------------------------------------------------
// st_pkg
//   Shared types and helpers for the broadcast stream splitter.
//
//   frame_state_e : frame tracking state. SOF means the next accepted beat
//                   opens a new frame; MID means a frame is in progress.
//   keep_width()  : number of byte-enable bits for a given data width.
// ---------------------------------------------------------------------------
package st_pkg;

    typedef enum logic {
        SOF = 1'b0,
        MID = 1'b1
    } frame_state_e;

    // One tkeep bit per data byte; data widths are whole bytes.
    function automatic int keep_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/st_fifo.sv
// ---------------------------------------------------------------------------
// st_fifo
//   Synchronous single-clock FIFO with a combinational read port.
//   The head entry is visible on rd_data whenever empty is low, so a word
//   pushed into an empty FIFO appears one cycle after the push edge.
//
// Parameters
//   WIDTH   : word width in bits
//   DEPTH   : number of entries (power of 2, >= 2)
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (empties the FIFO)
//   push     in   write wr_data this cycle (ignored when full)
//   wr_data  in   WIDTH  word to write
//   pop      in   discard the head entry this cycle (ignored when empty)
//   rd_data  out  WIDTH  head entry
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  number of stored entries
// ---------------------------------------------------------------------------
module st_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) bits wide, so the natural binary
    // overflow gives the modulo-DEPTH wrap. A simultaneous push and pop
    // moves both pointers and leaves the occupancy unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

endmodule

// File: rtl/st_bcast_splitter.sv
// ---------------------------------------------------------------------------
// st_bcast_splitter
//   Broadcasts one input stream to up to N_OUT output streams. Every output
//   channel has its own FIFO, so a slow channel only holds off the input
//   once its own buffer is full; the others keep draining.
//
//   The set of channels that receive a frame is taken from out_en_i at the
//   first beat of the frame and held for the rest of it.
//
// Parameters
//   DATA_W     : data width in bits (multiple of 8)
//   N_OUT      : number of output channels (1..8)
//   FIFO_DEPTH : per-channel buffer depth in beats (power of 2, >= 2)
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   s_tdata_i  in   DATA_W          input data
//   s_tkeep_i  in   DATA_W/8        input byte enables
//   s_tvld_i   in   input valid
//   s_tlast_i  in   input end of frame
//   s_trdy_o   out  input ready
//   out_en_i   in   N_OUT           channel enable mask, used at frame start
//   m_tdata_o  out  N_OUT*DATA_W    channel k at [k*DATA_W +: DATA_W]
//   m_tkeep_o  out  N_OUT*DATA_W/8  channel k at [k*DATA_W/8 +: DATA_W/8]
//   m_tvld_o   out  N_OUT           per-channel valid
//   m_tlast_o  out  N_OUT           per-channel end of frame
//   m_trdy_i   in   N_OUT           per-channel ready
//   busy_o     out  high while a frame is in progress
// ---------------------------------------------------------------------------
module st_bcast_splitter
    import st_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int N_OUT      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,

    input  logic [DATA_W-1:0]                    s_tdata_i,
    input  logic [keep_width(DATA_W)-1:0]        s_tkeep_i,
    input  logic                                 s_tvld_i,
    input  logic                                 s_tlast_i,
    output logic                                 s_trdy_o,

    input  logic [N_OUT-1:0]                     out_en_i,

    output logic [N_OUT*DATA_W-1:0]              m_tdata_o,
    output logic [N_OUT*keep_width(DATA_W)-1:0]  m_tkeep_o,
    output logic [N_OUT-1:0]                     m_tvld_o,
    output logic [N_OUT-1:0]                     m_tlast_o,
    input  logic [N_OUT-1:0]                     m_trdy_i,

    output logic                                 busy_o
);

    localparam int KEEP_W = keep_width(DATA_W);
    localparam int BEAT_W = DATA_W + KEEP_W + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    frame_state_e      state_q;
    frame_state_e      state_d;
    logic [N_OUT-1:0]  mask_q;
    logic [N_OUT-1:0]  mask_d;
    logic [N_OUT-1:0]  active_mask;
    logic [N_OUT-1:0]  full_vec;
    logic [N_OUT-1:0]  empty_vec;
    logic [N_OUT-1:0]  push_vec;
    logic [N_OUT-1:0]  pop_vec;
    logic              accept;
    logic [BEAT_W-1:0] wr_beat;
    logic [BEAT_W-1:0] rd_beat [N_OUT];
    logic [CNT_W-1:0]  cnt_vec [N_OUT];

    // At the start of a frame the live enable mask decides the destination
    // set, so a single-beat frame needs no extra cycle. Inside a frame the
    // captured mask is used and out_en_i is ignored.
    assign active_mask = (state_q == SOF) ? out_en_i : mask_q;

    // Only a full FIFO of a channel that takes part in the frame can stall
    // the input. Fullness is the registered count, so a pop in the same
    // cycle does not open space until the next cycle. An all-zero mask
    // therefore never stalls and the beat is simply dropped.
    assign s_trdy_o = ~|(active_mask & full_vec);
    assign accept   = s_tvld_i & s_trdy_o;
    assign push_vec = {N_OUT{accept}} & active_mask;
    assign wr_beat  = {s_tlast_i, s_tkeep_i, s_tdata_i};
    assign busy_o   = (state_q == MID);

    // Frame state and the captured destination mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SOF;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    // Frame tracking follows accepted beats only, including frames that go
    // nowhere, so the next frame boundary is always found correctly.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        if (accept) begin
            case (state_q)
                SOF: begin
                    mask_d = out_en_i;
                    if (!s_tlast_i) begin
                        state_d = MID;
                    end
                end
                MID: begin
                    if (s_tlast_i) begin
                        state_d = SOF;
                    end
                end
                default: state_d = SOF;
            endcase
        end
    end

    // One buffer per output channel; each pops on its own handshake.
    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        st_fifo #(
            .WIDTH (BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push_vec[k]),
            .wr_data (wr_beat),
            .pop     (pop_vec[k]),
            .rd_data (rd_beat[k]),
            .full    (full_vec[k]),
            .empty   (empty_vec[k]),
            .count   (cnt_vec[k])
        );

        assign m_tvld_o[k]                     = ~empty_vec[k];
        assign pop_vec[k]                      = m_tvld_o[k] & m_trdy_i[k];
        assign m_tdata_o[k*DATA_W +: DATA_W]   = rd_beat[k][DATA_W-1:0];
        assign m_tkeep_o[k*KEEP_W +: KEEP_W]   = rd_beat[k][DATA_W +: KEEP_W];
        assign m_tlast_o[k]                    = rd_beat[k][BEAT_W-1];

        // The occupancy never exceeds the depth and full tracks it exactly.
        a_cnt_sane : assert property (
            @(posedge clk) disable iff (!reset_n)
            (cnt_vec[k] <= CNT_W'(FIFO_DEPTH)) &&
            (full_vec[k] == (cnt_vec[k] == CNT_W'(FIFO_DEPTH)))
        );
    end

endmodule
